// File: rtl/fp_normalizer_if.sv
// Handshake and data bundle for the floating-point mantissa normalizer.
// The master side issues start/mant_in/exp_in and observes the results;
// the slave side (the normalizer) consumes the request and drives results.
interface fp_normalizer_if;
  logic        start;
  logic [26:0] mant_in;
  logic [7:0]  exp_in;
  logic        busy;
  logic        done;
  logic [26:0] mant_out;
  logic [7:0]  exp_out;
  logic [4:0]  shift_count;
  logic        zero;
  logic        underflow;
  logic        overflow;

  modport master (
    output start, mant_in, exp_in,
    input  busy, done, mant_out, exp_out, shift_count, zero, underflow, overflow
  );

  modport slave (
    input  start, mant_in, exp_in,
    output busy, done, mant_out, exp_out, shift_count, zero, underflow, overflow
  );
endinterface

// File: rtl/fp_normalizer.sv
// Iterative mantissa normalizer. A request latches a 27-bit mantissa
// (carry, hidden, 23 fraction, guard/sticky) with its biased exponent and
// then resolves it one step per clock: zero detect, one right shift on
// carry, or repeated left shifts until the hidden bit is set or the
// exponent bottoms out (denormal). All results are registered and held
// until the next accepted request.
module fp_normalizer (
  input  logic             clk,
  input  logic             rst_n,
  fp_normalizer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state;
  logic [26:0] mantReg;
  logic [7:0]  expReg;
  logic [4:0]  shiftCnt;
  logic        zeroFlag;
  logic        underFlag;
  logic        overFlag;
  logic        busyReg;
  logic        doneReg;

  // Control FSM and datapath registers updated together, one decision per cycle.
  // NOTE: every register here is state, so all assignments are non-blocking to
  // keep same-edge reads seeing the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, because the result outputs are
      // visible at all times and must read as zero while the block is reset.
      state     <= IDLE;
      mantReg   <= '0;
      expReg    <= '0;
      shiftCnt  <= '0;
      zeroFlag  <= 1'b0;
      underFlag <= 1'b0;
      overFlag  <= 1'b0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          doneReg <= 1'b0;
          if (bus.start) begin
            mantReg   <= bus.mant_in;
            expReg    <= bus.exp_in;
            shiftCnt  <= '0;
            zeroFlag  <= 1'b0;
            underFlag <= 1'b0;
            overFlag  <= 1'b0;
            busyReg   <= 1'b1;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (mantReg == '0) begin
            // Exact zero: exponent is forced to zero as well.
            zeroFlag <= 1'b1;
            expReg   <= '0;
            doneReg  <= 1'b1;
            state    <= DONE;
          end else if (mantReg[26]) begin
            // Carry out of the hidden bit: one right shift, folding the
            // dropped bit into sticky so rounding information survives.
            mantReg <= {1'b0, mantReg[26:2], mantReg[1] | mantReg[0]};
            if (expReg >= 8'd254) begin
              // Saturate at 255; an input exponent of 255 must not wrap.
              expReg   <= 8'd255;
              overFlag <= 1'b1;
            end else begin
              expReg <= expReg + 8'd1;
            end
            doneReg <= 1'b1;
            state   <= DONE;
          end else if (mantReg[25]) begin
            doneReg <= 1'b1;
            state   <= DONE;
          end else if (expReg <= 8'd1) begin
            // Exponent exhausted: leave the value denormal.
            underFlag <= 1'b1;
            doneReg   <= 1'b1;
            state     <= DONE;
          end else begin
            mantReg  <= {mantReg[25:0], 1'b0};
            expReg   <= expReg - 8'd1;
            shiftCnt <= shiftCnt + 5'd1;
          end
        end

        DONE: begin
          // Single-cycle done; a start seen here is deliberately not sampled.
          doneReg <= 1'b0;
          busyReg <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busyReg;
  assign bus.done        = doneReg;
  assign bus.mant_out    = mantReg;
  assign bus.exp_out     = expReg;
  assign bus.shift_count = shiftCnt;
  assign bus.zero        = zeroFlag;
  assign bus.underflow   = underFlag;
  assign bus.overflow    = overFlag;

endmodule

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 The module SHALL have a port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-002 The module SHALL have a port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-003 The module SHALL have a port start, input, 1 bit, request to normalize; sampled only in IDLE.
REQ-004 The module SHALL have a port mant_in, input, 27 bits: bit 26 carry, bit 25 hidden, bits 24:2 fraction, bits 1:0 guard/sticky.
REQ-005 The module SHALL have a port exp_in, input, 8 bits, biased exponent paired with mant_in.
REQ-006 The module SHALL have a port busy, output, 1 bit, high from the cycle after start is accepted until done.
REQ-007 The module SHALL have a port done, output, 1 bit, a single-cycle pulse marking valid results.
REQ-008 The module SHALL have a port mant_out, output, 27 bits, normalized mantissa in the same layout as mant_in.
REQ-009 The module SHALL have a port exp_out, output, 8 bits, adjusted biased exponent.
REQ-010 The module SHALL have a port shift_count, output, 5 bits, number of left shifts performed.
REQ-011 The module SHALL have ports zero, underflow and overflow, outputs, 1 bit each, result status flags.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1: on the clock edge, latch mant_in and exp_in, clear shift_count and all flags, and go to SHIFT.
REQ-014 In SHIFT, evaluate the registered mantissa m and exponent e once per cycle, in priority order (REQ-015 to REQ-019).
REQ-015 Priority 1, m==0: set zero=1, force exp_out=0, go to DONE.
REQ-016 Priority 2, m[26]==1: m = {0, m[26:2], m[1]|m[0]} (sticky preserved), e = e+1, go to DONE; if the new e==255, set overflow=1.
REQ-017 Priority 3, m[25]==1: already normalized, go to DONE unchanged.
REQ-018 Priority 4, e<=1: stop shifting, set underflow=1, go to DONE with m unchanged (denormal result).
REQ-019 Otherwise: m = m<<1 with zero fill, e = e-1, shift_count = shift_count+1, stay in SHIFT.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-022 Latency: done SHALL be high during the cycle k+2 edges after the start edge, where k = left shifts (0 for zero, right-shift or normalized input); maximum k=25, maximum latency 27 cycles.
REQ-023 start while busy=1 SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-024 start asserted in the DONE cycle SHALL be ignored; a new operation is accepted only in IDLE.
REQ-025 mant_out, exp_out, shift_count and flags SHALL hold their final values from DONE until the next accepted start.
REQ-026 exp_in==255 with m[26]==1 SHALL saturate exp_out at 255 with overflow=1, with no wrap to 0.
REQ-027 Back-to-back operation: start held high SHALL begin a new operation on the first IDLE cycle after DONE.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE and busy=0, done=0, mant_out=0, exp_out=0, shift_count=0, zero=0, underflow=0, overflow=0.
REQ-029 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; after release, the block waits in IDLE for a new start.

Verification
REQ-030 Scenario: mant_in=27'h2000000, exp_in=8'd127, start pulse -> done 2 cycles later; mant_out=27'h2000000, exp_out=127, shift_count=0, no flags.
REQ-031 Scenario: mant_in=27'h4000003, exp_in=8'd100 -> done after 2 cycles; mant_out=27'h2000001, exp_out=101, shift_count=0.
REQ-032 Scenario: mant_in=27'h0000400 (bit 10), exp_in=8'd130 -> 15 shifts, done 17 cycles after start; mant_out=27'h2000000, exp_out=115, shift_count=15.
REQ-033 Scenario: mant_in=27'h0000400, exp_in=8'd4 -> 3 shifts, then underflow=1; exp_out=1, mant_out=27'h0002000, shift_count=3.
REQ-034 Scenario: mant_in=0 -> zero=1, exp_out=0, done after 2 cycles; second case mant_in=27'h4000000, exp_in=254 -> exp_out=255, overflow=1.
REQ-035 Scenario: start an 15-shift operation, pulse rst_n low at cycle 5 -> outputs clear asynchronously, no done pulse; a subsequent start completes normally, and a start pulse during busy changes nothing.
